// File: rtl/video_timing_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_ctrl_pkg
//  Description : Shared timing definitions for video_timing_ctrl.
//                - Default 1280x720@60 timing constants.
//                - Derived line and frame totals.
//                - Counter widths and sequencer state encodings.
//                - Small region-decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_timing_ctrl_pkg;

    localparam int C_CNT_W        = 12;
    localparam int C_POS_W        = 11;

    localparam int C_H_SYNC_DEF   = 40;
    localparam int C_H_BACK_DEF   = 220;
    localparam int C_H_DISP_DEF   = 1280;
    localparam int C_H_FRONT_DEF  = 110;
    localparam int C_V_SYNC_DEF   = 5;
    localparam int C_V_BACK_DEF   = 20;
    localparam int C_V_DISP_DEF   = 720;
    localparam int C_V_FRONT_DEF  = 5;

    localparam int C_H_TOTAL_DEF  = C_H_SYNC_DEF + C_H_BACK_DEF + C_H_DISP_DEF + C_H_FRONT_DEF;
    localparam int C_V_TOTAL_DEF  = C_V_SYNC_DEF + C_V_BACK_DEF + C_V_DISP_DEF + C_V_FRONT_DEF;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_STOP = 2'd2;

    // Half-open window test: lo <= cnt < hi
    function automatic logic in_window(input logic [C_CNT_W-1:0] cnt,
                                       input logic [C_CNT_W-1:0] lo,
                                       input logic [C_CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_ctrl_sig_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sig_delay
//  Description : Parameterised-depth, parameterised-width shift register with
//                synchronous reset to RST_VAL. DEPTH=0 is a wire.
//  Ports       : clk    - clock
//                rst    - synchronous active-high reset
//                i_data - value entering the line
//                o_data - value DEPTH cycles later
//  Revision    : 1.0 - initial release
// ============================================================================
module sig_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_data = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_pipe_q [DEPTH];
            logic [WIDTH-1:0] w_pipe_d [DEPTH];

            always_comb begin
                w_pipe_d[0] = i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    w_pipe_d[i] = r_pipe_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rst) begin
                        r_pipe_q[i] <= RST_VAL;
                    end else begin
                        r_pipe_q[i] <= w_pipe_d[i];
                    end
                end
            end

            assign o_data = r_pipe_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/video_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_ctrl
//  Description : Video timing sequencer for a DVI transmitter. Generates
//                hsync/vsync/data-enable plus a pixel request strobe with
//                coordinates that leads video_de by REQ_LEAD cycles. Starts
//                and stops only on frame boundaries.
//  Ports       : pclk, reset (sync, active-high), enable (run request)
//                pixel_req/pixel_xpos/pixel_ypos - stage-0 pixel request
//                frame_start - stage-0 pulse at counter (0,0)
//                video_hsync/video_vsync/video_de - delayed by REQ_LEAD
//                busy - sequencer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_ctrl
    import video_timing_ctrl_pkg::*;
#(
    parameter int H_SYNC   = C_H_SYNC_DEF,
    parameter int H_BACK   = C_H_BACK_DEF,
    parameter int H_DISP   = C_H_DISP_DEF,
    parameter int H_FRONT  = C_H_FRONT_DEF,
    parameter int V_SYNC   = C_V_SYNC_DEF,
    parameter int V_BACK   = C_V_BACK_DEF,
    parameter int V_DISP   = C_V_DISP_DEF,
    parameter int V_FRONT  = C_V_FRONT_DEF,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int REQ_LEAD = 1
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               enable,
    output logic               pixel_req,
    output logic [C_POS_W-1:0] pixel_xpos,
    output logic [C_POS_W-1:0] pixel_ypos,
    output logic               frame_start,
    output logic               video_hsync,
    output logic               video_vsync,
    output logic               video_de,
    output logic               busy
);

    localparam logic [C_CNT_W-1:0] C_H_LAST   = C_CNT_W'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [C_CNT_W-1:0] C_V_LAST   = C_CNT_W'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [C_CNT_W-1:0] C_H_SYNC_E = C_CNT_W'(H_SYNC);
    localparam logic [C_CNT_W-1:0] C_V_SYNC_E = C_CNT_W'(V_SYNC);
    localparam logic [C_CNT_W-1:0] C_H_ACT_LO = C_CNT_W'(H_SYNC + H_BACK);
    localparam logic [C_CNT_W-1:0] C_H_ACT_HI = C_CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [C_CNT_W-1:0] C_V_ACT_LO = C_CNT_W'(V_SYNC + V_BACK);
    localparam logic [C_CNT_W-1:0] C_V_ACT_HI = C_CNT_W'(V_SYNC + V_BACK + V_DISP);
    localparam logic [C_CNT_W-1:0] C_ONE      = C_CNT_W'(1);
    localparam logic [2:0]         C_DLY_RST  = {~HS_POL, ~VS_POL, 1'b0};

    logic [1:0]         r_state_q, w_state_d;
    logic [C_CNT_W-1:0] r_h_cnt_q, w_h_cnt_d;
    logic [C_CNT_W-1:0] r_v_cnt_q, w_v_cnt_d;
    logic               w_active, w_at_last, w_frame_start;
    logic               w_hs, w_vs, w_de;
    logic [C_POS_W-1:0] w_xpos, w_ypos;

    logic               r_pixel_req_q, w_pixel_req_d;
    logic [C_POS_W-1:0] r_xpos_q, w_xpos_d;
    logic [C_POS_W-1:0] r_ypos_q, w_ypos_d;
    logic               r_frame_start_q, w_frame_start_d;
    logic               r_hs_q, w_hs_d;
    logic               r_vs_q, w_vs_d;
    logic               r_busy_q, w_busy_d;
    logic [2:0]         w_video;

    assign w_at_last = (r_h_cnt_q == C_H_LAST) && (r_v_cnt_q == C_V_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state_q <= C_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // Leaving RUN/STOP only happens on the last counter position, so a
    // started frame always runs to completion.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            C_ST_IDLE: if (enable) w_state_d = C_ST_RUN;
            C_ST_RUN: begin
                if (w_at_last)    w_state_d = enable ? C_ST_RUN : C_ST_IDLE;
                else if (!enable) w_state_d = C_ST_STOP;
            end
            C_ST_STOP: begin
                if (w_at_last)    w_state_d = C_ST_IDLE;
                else if (enable)  w_state_d = C_ST_RUN;
            end
            default:              w_state_d = C_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_active      = (r_state_q != C_ST_IDLE);
        w_frame_start = (r_state_q == C_ST_RUN) && (r_h_cnt_q == '0) && (r_v_cnt_q == '0);
    end

    // ---------------- raster counters ----------------
    always_comb begin
        w_h_cnt_d = '0;
        w_v_cnt_d = '0;
        if (w_active) begin
            if (r_h_cnt_q == C_H_LAST) begin
                w_v_cnt_d = (r_v_cnt_q == C_V_LAST) ? '0 : r_v_cnt_q + C_ONE;
            end else begin
                w_h_cnt_d = r_h_cnt_q + C_ONE;
                w_v_cnt_d = r_v_cnt_q;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_h_cnt_q <= '0;
            r_v_cnt_q <= '0;
        end else begin
            r_h_cnt_q <= w_h_cnt_d;
            r_v_cnt_q <= w_v_cnt_d;
        end
    end

    // ---------------- region decode ----------------
    always_comb begin
        w_hs   = w_active && (r_h_cnt_q < C_H_SYNC_E);
        w_vs   = w_active && (r_v_cnt_q < C_V_SYNC_E);
        w_de   = w_active && in_window(r_h_cnt_q, C_H_ACT_LO, C_H_ACT_HI)
                          && in_window(r_v_cnt_q, C_V_ACT_LO, C_V_ACT_HI);
        w_xpos = C_POS_W'(r_h_cnt_q - C_H_ACT_LO);
        w_ypos = C_POS_W'(r_v_cnt_q - C_V_ACT_LO);
    end

    // ---------------- stage 0 ----------------
    // Syncs are held at their physical line levels from here on, so the
    // delay line and its reset value already carry the output polarity.
    always_comb begin
        w_pixel_req_d   = w_de;
        w_xpos_d        = w_de ? w_xpos : '0;
        w_ypos_d        = w_de ? w_ypos : '0;
        w_frame_start_d = w_frame_start;
        w_hs_d          = w_hs ? HS_POL : ~HS_POL;
        w_vs_d          = w_vs ? VS_POL : ~VS_POL;
        w_busy_d        = (w_state_d != C_ST_IDLE);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_pixel_req_q   <= 1'b0;
            r_xpos_q        <= '0;
            r_ypos_q        <= '0;
            r_frame_start_q <= 1'b0;
            r_hs_q          <= ~HS_POL;
            r_vs_q          <= ~VS_POL;
            r_busy_q        <= 1'b0;
        end else begin
            r_pixel_req_q   <= w_pixel_req_d;
            r_xpos_q        <= w_xpos_d;
            r_ypos_q        <= w_ypos_d;
            r_frame_start_q <= w_frame_start_d;
            r_hs_q          <= w_hs_d;
            r_vs_q          <= w_vs_d;
            r_busy_q        <= w_busy_d;
        end
    end

    // ---------------- stage 0 -> transmitter alignment ----------------
    sig_delay #(
        .DEPTH   (REQ_LEAD),
        .WIDTH   (3),
        .RST_VAL (C_DLY_RST)
    ) u_sig_delay (
        .clk    (pclk),
        .rst    (reset),
        .i_data ({r_hs_q, r_vs_q, r_pixel_req_q}),
        .o_data (w_video)
    );

    assign pixel_req   = r_pixel_req_q;
    assign pixel_xpos  = r_xpos_q;
    assign pixel_ypos  = r_ypos_q;
    assign frame_start = r_frame_start_q;
    assign busy        = r_busy_q;
    assign video_hsync = w_video[2];
    assign video_vsync = w_video[1];
    assign video_de    = w_video[0];

endmodule
`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_ctrl
//  Description : Self-checking bench for video_timing_ctrl using a reduced
//                video mode. Three instances share enable/reset:
//                  inst0 REQ_LEAD=1, HS_POL=1, VS_POL=1
//                  inst1 REQ_LEAD=0, HS_POL=0, VS_POL=0
//                  inst2 REQ_LEAD=3, HS_POL=1, VS_POL=0
//                A frame-position reference model checks every cycle; a
//                hand-derived event table and directed sequences check the
//                key timing points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_ctrl;

    localparam int HS = 3, HB = 4, HD = 8, HF = 2;
    localparam int VS = 2, VB = 3, VD = 4, VF = 2;
    localparam int HT = HS + HB + HD + HF;     // 17
    localparam int VT = VS + VB + VD + VF;     // 11
    localparam int FR = HT * VT;               // 187

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en  = 1'b0;

    logic        req  [3];
    logic [10:0] xp   [3];
    logic [10:0] yp   [3];
    logic        fs   [3];
    logic        hs   [3];
    logic        vs   [3];
    logic        de   [3];
    logic        busy [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        video_timing_ctrl #(
            .H_SYNC (HS), .H_BACK (HB), .H_DISP (HD), .H_FRONT (HF),
            .V_SYNC (VS), .V_BACK (VB), .V_DISP (VD), .V_FRONT (VF),
            .HS_POL   (g != 1),
            .VS_POL   (g == 0),
            .REQ_LEAD (g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .pclk        (clk),
            .reset       (rst),
            .enable      (en),
            .pixel_req   (req[g]),
            .pixel_xpos  (xp[g]),
            .pixel_ypos  (yp[g]),
            .frame_start (fs[g]),
            .video_hsync (hs[g]),
            .video_vsync (vs[g]),
            .video_de    (de[g]),
            .busy        (busy[g])
        );
    end

    function automatic int lead_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction
    function automatic bit hpol_of(int g);
        return g != 1;
    endfunction
    function automatic bit vpol_of(int g);
        return g == 0;
    endfunction

    int checks   = 0;
    int failures = 0;
    int j        = 0;
    int cnt_req  = 0;
    int cnt_de   = 0;
    int cnt_fs   = 0;

    // ---------------- reference model state ----------------
    bit          m_run, m_stop, m_req, m_fs, m_busy;
    int          m_pos;
    logic [10:0] m_x, m_y;
    bit          h_hs [5];   // h_xx[k] = stage-0 value k cycles ago (active=1)
    bit          h_vs [5];
    bit          h_de [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
        end
    endtask

    // Advances the model with the current inputs, clocks once, then compares
    // every instance against the model at the falling edge.
    task automatic step();
        int          h, v, ld;
        bit          nreq, nhs, nvs, nfs, ehs, evs;
        logic [10:0] nx, ny;
        logic [27:0] act, exp;
        if (rst) begin
            m_run = 0; m_stop = 0; m_pos = 0;
            m_req = 0; m_fs = 0; m_busy = 0; m_x = '0; m_y = '0;
            for (int k = 0; k < 5; k++) begin
                h_hs[k] = 0; h_vs[k] = 0; h_de[k] = 0;
            end
        end else begin
            h    = m_pos % HT;
            v    = m_pos / HT;
            nreq = m_run && (h >= HS + HB) && (h < HS + HB + HD)
                         && (v >= VS + VB) && (v < VS + VB + VD);
            nx   = nreq ? 11'(h - HS - HB) : 11'd0;
            ny   = nreq ? 11'(v - VS - VB) : 11'd0;
            nfs  = m_run && !m_stop && (m_pos == 0);
            nhs  = m_run && (h < HS);
            nvs  = m_run && (v < VS);
            if (!m_run) begin
                if (en) begin m_run = 1; m_stop = 0; m_pos = 0; end
            end else if (m_pos == FR - 1) begin
                if (m_stop || !en) m_run = 0;
                m_stop = 0;
                m_pos  = 0;
            end else begin
                m_pos++;
                m_stop = !en;
            end
            m_busy = m_run;
            m_req = nreq; m_x = nx; m_y = ny; m_fs = nfs;
            for (int k = 4; k > 0; k--) begin
                h_hs[k] = h_hs[k-1]; h_vs[k] = h_vs[k-1]; h_de[k] = h_de[k-1];
            end
            h_hs[0] = nhs; h_vs[0] = nvs; h_de[0] = nreq;
        end

        @(posedge clk);
        @(negedge clk);
        j++;

        for (int g = 0; g < 3; g++) begin
            ld  = lead_of(g);
            ehs = h_hs[ld] ? hpol_of(g) : !hpol_of(g);
            evs = h_vs[ld] ? vpol_of(g) : !vpol_of(g);
            act = {req[g], xp[g], yp[g], fs[g], busy[g], hs[g], vs[g], de[g]};
            exp = {m_req, m_x, m_y, m_fs, m_busy, ehs, evs, h_de[ld]};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL model inst%0d t=%0t got=%h exp=%h", g, $time, act, exp);
            end
        end
        if (req[0]) cnt_req++;
        if (de[0])  cnt_de++;
        if (fs[0])  cnt_fs++;
    endtask

    // ---------------- hand-derived event table ----------------
    typedef struct {
        int j;      // cycles after enable sampled, minus one (0 = counter at (0,0))
        int sel;    // observed signal
        int exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int jj, input int sel, input int exp);
        vec_t e;
        e.j = jj; e.sel = sel; e.exp = exp;
        tbl.push_back(e);
    endtask

    function automatic int sig(int sel);
        case (sel)
            0:  return int'(fs[0]);
            1:  return int'(busy[0]);
            2:  return int'(hs[0]);
            3:  return int'(vs[0]);
            4:  return int'(req[0]);
            5:  return int'(de[0]);
            6:  return int'(xp[0]);
            7:  return int'(yp[0]);
            8:  return int'(hs[1]);
            9:  return int'(de[1]);
            10: return int'(req[1]);
            default: return -1;
        endcase
    endfunction

    initial begin
        int guard, fall_j, r;
        bit fast;

        // sorted by j; sel codes as in sig()
        add(0, 1, 1);  add(0, 0, 0);  add(0, 2, 0);  add(0, 8, 1);
        add(1, 0, 1);  add(1, 2, 0);  add(1, 8, 0);
        add(2, 2, 1);  add(2, 3, 1);
        add(3, 8, 0);
        add(4, 2, 1);  add(4, 8, 1);
        add(5, 2, 0);
        add(35, 3, 1);
        add(36, 3, 0);
        add(92, 4, 0);
        add(93, 4, 1); add(93, 6, 0); add(93, 7, 0); add(93, 5, 0); add(93, 9, 1); add(93, 10, 1);
        add(94, 5, 1);
        add(151, 6, 7); add(151, 7, 3);
        add(152, 4, 0);
        add(187, 0, 0);
        add(188, 0, 1);

        // reset, then long idle with enable low
        rst = 1'b1; en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (5000) step();
        chk("idle_busy", int'(busy[0]), 0);
        chk("idle_hsync_inst1", int'(hs[1]), 1);

        // enable rises; table-driven timing points
        en = 1'b1;
        j  = -1;
        foreach (tbl[i]) begin
            while (j < tbl[i].j) step();
            chk($sformatf("tbl_j%0d_sel%0d", tbl[i].j, tbl[i].sel), sig(tbl[i].sel), tbl[i].exp);
        end

        // drop enable during line 6 of the second frame
        cnt_req = 0; cnt_de = 0; cnt_fs = 0;
        while (j < FR + 6 * HT) step();
        en = 1'b0;
        guard = 0;
        while (busy[0] && guard < 400) begin
            step();
            guard++;
        end
        fall_j = j;
        chk("busy_fall_cycle", fall_j, 2 * FR);
        repeat (40) step();
        chk("stop_frame_req_count", cnt_req, HD * VD);
        chk("stop_frame_de_count", cnt_de, HD * VD);
        chk("stop_frame_no_new_fs", cnt_fs, 0);

        // reset during active video, then restart
        en = 1'b1;
        guard = 0;
        while (!req[0] && guard < 300) begin
            step();
            guard++;
        end
        chk("reach_active_video", int'(req[0]), 1);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rst_mid_inst0", int'({de[0], req[0], busy[0], hs[0], vs[0]}), 0);
        chk("rst_mid_inst1", int'({de[1], hs[1], vs[1]}), 3);
        rst = 1'b0;
        step();
        chk("restart_fs_n1", int'(fs[0]), 0);
        chk("restart_busy_n1", int'(busy[0]), 1);
        step();
        chk("restart_fs_n2", int'(fs[0]), 1);

        // randomized enable/reset traffic against the model
        fast = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (c % 1000 == 0) fast = bit'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 999));
            rst = (r < 2);
            if (fast ? (r < 120) : (r < 5)) en = !en;
            step();
        end
        rst = 1'b0;
        en  = 1'b0;
        repeat (2 * FR + 10) step();
        chk("final_idle_busy", int'(busy[2]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
